// File: rtl/wide_enum_pkg.sv
// Shared types and encoding helper for the wide enumeration stepper.
package wide_enum_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_FIRST = 3'd1,
    OP_LAST  = 3'd2,
    OP_NEXT  = 3'd3,
    OP_PREV  = 3'd4
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_e;

  // One lane of enc(i); callers replicate it across the full width and truncate the top lane.
  function automatic logic [LANE_W-1:0] enc_lane(input int unsigned i);
    return LANE_W'(i + 1);
  endfunction

endpackage

// File: rtl/wide_enum_lookup.sv
// Reverse lookup: maps a WIDTH-bit value to its member index, or NUM_ELEMS when it is not a member.
module wide_enum_lookup
  import wide_enum_pkg::*;
#(
  parameter int WIDTH     = 160,
  parameter int NUM_ELEMS = 4,
  parameter int IDX_W     = 3
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [IDX_W-1:0] o_index,
  output logic             o_legal
);

  localparam int NL = (WIDTH + LANE_W - 1) / LANE_W;

  logic [NUM_ELEMS-1:0] w_hit;

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_cmp
    assign w_hit[g] = (i_value == WIDTH'({NL{enc_lane(g)}}));
  end

  // Narrow widths can alias encodings; the lowest matching index wins.
  always_comb begin
    o_index = IDX_W'(NUM_ELEMS);
    for (int k = NUM_ELEMS - 1; k >= 0; k--) begin
      if (w_hit[k]) o_index = IDX_W'(k);
    end
  end

  assign o_legal = |w_hit;

endmodule

// File: rtl/wide_enum_stepper.sv
// Wide enum value holder with load/first/last/next(n)/prev(n) and wrap-around stepping.
// Optional WIDE_ENUM_TRACE_EN prints the member name (or illegal hex value) whenever value_o changes.
//
// state   | meaning
// ST_IDLE | ready for a command; single-cycle ops complete from here
// ST_STEP | multi-step NEXT/PREV walking one member per clock
module wide_enum_stepper
  import wide_enum_pkg::*;
#(
  parameter  int WIDTH     = 160,
  parameter  int NUM_ELEMS = 4,
  parameter  int CNT_W     = 8,
  localparam int IDX_W     = $clog2(NUM_ELEMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_cnt_i,
  input  logic [WIDTH-1:0] cmd_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic [IDX_W-1:0] index_o,
  output logic             legal_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int NL    = (WIDTH + LANE_W - 1) / LANE_W;
  localparam int ENC_N = 1 << IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_ELEMS - 1);
  localparam logic [WIDTH-1:0] ENC_FIRST = WIDTH'({NL{enc_lane(0)}});

  state_e           r_state;
  logic [WIDTH-1:0] r_value;
  logic [IDX_W-1:0] r_index;
  logic             r_legal;
  logic             r_dir;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_remaining;

  logic [WIDTH-1:0] w_enc [ENC_N];
  logic [IDX_W-1:0] w_load_index;
  logic             w_load_legal;
  logic             w_dir;
  logic [IDX_W-1:0] w_step_index;

  for (genvar g = 0; g < ENC_N; g++) begin : g_enc
    if (g < NUM_ELEMS) begin : g_mem
      assign w_enc[g] = WIDTH'({NL{enc_lane(g)}});
    end else begin : g_pad
      assign w_enc[g] = '0;
    end
  end

  wide_enum_lookup #(
    .WIDTH     (WIDTH),
    .NUM_ELEMS (NUM_ELEMS),
    .IDX_W     (IDX_W)
  ) u_lookup (
    .i_value (cmd_val_i),
    .o_index (w_load_index),
    .o_legal (w_load_legal)
  );

  // Direction comes from the live command on the accept edge, then from the latched copy.
  assign w_dir = (r_state == ST_STEP) ? r_dir : (cmd_op_i == OP_PREV);

  always_comb begin
    w_step_index = '0;
    if (w_dir) begin
      w_step_index = (r_index == '0) ? IDX_LAST : r_index - IDX_W'(1);
    end else begin
      w_step_index = (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_value     <= ENC_FIRST;
      r_index     <= '0;
      r_legal     <= 1'b1;
      r_dir       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            r_done <= 1'b1;
            case (cmd_op_i)
              OP_LOAD: begin
                r_value <= cmd_val_i;
                r_index <= w_load_index;
                r_legal <= w_load_legal;
              end
              OP_FIRST: begin
                r_value <= w_enc[0];
                r_index <= '0;
                r_legal <= 1'b1;
              end
              OP_LAST: begin
                r_value <= w_enc[IDX_LAST];
                r_index <= IDX_LAST;
                r_legal <= 1'b1;
              end
              OP_NEXT, OP_PREV: begin
                if (!r_legal) begin
                  r_err <= 1'b1;
                end else begin
                  // First step is taken on the accept edge; STEP only covers the rest.
                  r_value <= w_enc[w_step_index];
                  r_index <= w_step_index;
                  r_dir   <= w_dir;
                  if (cmd_cnt_i > CNT_W'(1)) begin
                    r_done      <= 1'b0;
                    r_remaining <= cmd_cnt_i - CNT_W'(1);
                    r_state     <= ST_STEP;
                  end
                end
              end
              default: r_err <= 1'b1;
            endcase
          end
        end
        ST_STEP: begin
          r_value     <= w_enc[w_step_index];
          r_index     <= w_step_index;
          r_remaining <= r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state == ST_STEP);
  assign value_o     = r_value;
  assign index_o     = r_index;
  assign legal_o     = r_legal;
  assign done_o      = r_done;
  assign err_o       = r_err;

`ifdef WIDE_ENUM_TRACE_EN
  logic [WIDTH-1:0] r_trace_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trace_prev <= ENC_FIRST;
    end else begin
      r_trace_prev <= r_value;
      if (r_value != r_trace_prev) begin
        if (r_legal) $display("E%0d", r_index);
        else         $display("<illegal> %0h", r_value);
      end
    end
  end
`endif

endmodule

// File: tb/tb_wide_enum_stepper.sv
// Randomized self-checking bench for wide_enum_stepper against a modular-arithmetic reference model.
module tb_wide_enum_stepper;

  parameter int WIDTH     = 160;
  parameter int NUM_ELEMS = 4;
  parameter int CNT_W     = 8;
  localparam int IDX_W    = $clog2(NUM_ELEMS + 1);
  localparam int CW       = (WIDTH > 32) ? WIDTH : 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op_i = 3'd0;
  logic [CNT_W-1:0] cmd_cnt_i = '0;
  logic [WIDTH-1:0] cmd_val_i = '0;
  logic [WIDTH-1:0] value_o;
  logic [IDX_W-1:0] index_o;
  logic             legal_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  int errors = 0;
  int checks = 0;

  int               m_idx;
  bit               m_legal;
  logic [WIDTH-1:0] m_val;

  always #5 clk = ~clk;

  wide_enum_stepper #(
    .WIDTH     (WIDTH),
    .NUM_ELEMS (NUM_ELEMS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_cnt_i   (cmd_cnt_i),
    .cmd_val_i   (cmd_val_i),
    .value_o     (value_o),
    .index_o     (index_o),
    .legal_o     (legal_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Member i: bit b carries bit (b mod 32) of the number i+1.
  function automatic logic [WIDTH-1:0] enc(input int i);
    logic [WIDTH-1:0] v;
    logic [31:0]      num;
    num = 32'(i + 1);
    for (int b = 0; b < WIDTH; b++) v[b] = num[b % 32];
    return v;
  endfunction

  task automatic lookup(input logic [WIDTH-1:0] v, output int idx, output bit legal);
    idx   = NUM_ELEMS;
    legal = 1'b0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (!legal && v == enc(i)) begin
        idx   = i;
        legal = 1'b1;
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] v;
    for (int b = 0; b < WIDTH; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, ".value"}, CW'(value_o), CW'(m_val));
    chk({tag, ".index"}, CW'(index_o), CW'(m_idx));
    chk({tag, ".legal"}, CW'(legal_o), CW'(m_legal));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic do_cmd(input string tag, input logic [2:0] op, input int cnt,
                        input logic [WIDTH-1:0] val, input bit noise);
    int lat;
    int n;
    bit exp_err;
    chk({tag, ".ready"}, CW'(cmd_ready_o), CW'(1));
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_cnt_i   = CNT_W'(cnt);
    cmd_val_i   = val;
    lat     = 1;
    exp_err = 1'b0;
    case (op)
      3'd0: begin
        m_val = val;
        lookup(val, m_idx, m_legal);
      end
      3'd1: begin
        m_idx = 0; m_legal = 1'b1; m_val = enc(0);
      end
      3'd2: begin
        m_idx = NUM_ELEMS - 1; m_legal = 1'b1; m_val = enc(NUM_ELEMS - 1);
      end
      3'd3, 3'd4: begin
        if (!m_legal) begin
          exp_err = 1'b1;
        end else begin
          n   = (cnt == 0) ? 1 : cnt;
          lat = n;
          if (op == 3'd3) m_idx = (m_idx + n) % NUM_ELEMS;
          else            m_idx = ((m_idx - n) % NUM_ELEMS + NUM_ELEMS) % NUM_ELEMS;
          m_val = enc(m_idx);
        end
      end
      default: exp_err = 1'b1;
    endcase
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (noise && c < lat) begin
        cmd_valid_i = 1'($urandom_range(0, 1));
        cmd_op_i    = 3'($urandom_range(0, 7));
        cmd_cnt_i   = CNT_W'($urandom_range(0, 3));
        cmd_val_i   = rand_wide();
      end else begin
        cmd_valid_i = 1'b0;
      end
      chk({tag, ".busy"}, CW'(busy_o), CW'(c < lat));
      chk({tag, ".done"}, CW'(done_o), CW'(c == lat));
      if (c == lat) begin
        chk({tag, ".err"}, CW'(err_o), CW'(exp_err));
        chk_state(tag);
      end
    end
  endtask

  task automatic idle_gap(input string tag);
    @(negedge clk);
    chk({tag, ".done_low"}, CW'(done_o), CW'(0));
    chk({tag, ".err_low"}, CW'(err_o), CW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [159:0] ill_const;
    logic [2:0]   op;
    int           cnt;
    logic [WIDTH-1:0] val;
    ill_const = 160'h1234_4567_abcd_1234_4567_abcd;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_idx = 0; m_legal = 1'b1; m_val = enc(0);
    chk_state("rst");
    chk("rst.ready", CW'(cmd_ready_o), CW'(1));
    chk("rst.busy", CW'(busy_o), CW'(0));
    chk("rst.done", CW'(done_o), CW'(0));
    chk("rst.err", CW'(err_o), CW'(0));

    do_cmd("next3", 3'd3, 3, '0, 1'b0);
    idle_gap("next3");
    do_cmd("first", 3'd1, 0, '0, 1'b0);
    do_cmd("next5", 3'd3, 5, '0, 1'b1);
    do_cmd("prev2", 3'd4, 2, '0, 1'b0);
    idle_gap("prev2");
    do_cmd("ill_load", 3'd0, 0, WIDTH'(ill_const), 1'b0);
    do_cmd("ill_next", 3'd3, 2, '0, 1'b0);
    do_cmd("rsvd6", 3'd6, 0, rand_wide(), 1'b0);
    do_cmd("load2", 3'd0, 0, enc(2), 1'b0);
    do_cmd("next0", 3'd3, 0, '0, 1'b0);
    do_cmd("last", 3'd2, 0, '0, 1'b0);
    idle_gap("last");

    cmd_valid_i = 1'b1;
    cmd_op_i    = 3'd3;
    cmd_cnt_i   = CNT_W'(10);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("midrst.busy_before", CW'(busy_o), CW'(1));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_idx = 0; m_legal = 1'b1; m_val = enc(0);
    chk_state("midrst");
    chk("midrst.busy", CW'(busy_o), CW'(0));
    chk("midrst.ready", CW'(cmd_ready_o), CW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("midrst.no_done", CW'(done_o), CW'(0));
    end
    chk_state("midrst.after");

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 3'd0;
        2:       op = 3'd1;
        3:       op = 3'd2;
        4, 5:    op = 3'd3;
        6, 7:    op = 3'd4;
        default: op = 3'($urandom_range(0, 7));
      endcase
      cnt = $urandom_range(0, 12);
      if ($urandom_range(0, 9) < 7) val = enc($urandom_range(0, NUM_ELEMS - 1));
      else                          val = rand_wide();
      do_cmd("rand", op, cnt, val, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_gap("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
